status_reg_reader: RTL and testbench
====================================

// Module: status_reg_reader
// PURPOSE
//  PL->PS readback path; the read-side counterpart of the byte-serial GPIO config-register write path.
//  - Snapshots a wide PL status word (reg_in) coherently.
//  - Returns the snapshot to the PS one word_width-bit byte per GPIO read handshake, most significant byte first.
//  - Sits at top level beside the config registers; instances share gpio_in.
//  - Top level ORs the gpio_out buses of all instances, so an unselected instance drives all zeros.
// PARAMETERS
//  word_width  8   bits per transferred byte (1..8)
//  num_words   4   bytes per snapshot (>=1)
//  addr_width  16  GPIO address width in bits
//  bus_addr    0   GPIO address of this instance; set in the top-level file
// PORTS
//  clk       input   1                      system clock
//  rst       input   1                      asynchronous, active-low reset
//  gpio_in   input   32                     PS GPIO bus: [15:0] addr, [24] w_clk, [25] r_clk
//  reg_in    input   num_words*word_width   live PL status word to be read back
//  gpio_out  output  32                     [word_width-1:0] data byte, [30] ack, [31] last; other bits 0
//  sel       output  1                      high while this instance holds or presents a byte
// BEHAVIOUR
//  Reset (rst low, async)
//  - gpio_out=0, sel=0, snapshot=0, byte index=0, state=IDLE.
//  - Synchronizer flops are cleared.
//  Input synchronization
//  - r_clk and w_clk each pass through a 2-flop synchronizer.
//  - addr is sampled only while the synchronized strobe is high; the PS holds addr stable across a strobe.
//  State machine: IDLE, PRESENT, WAIT_LOW
//  - IDLE: sync r_clk=1 and addr==bus_addr -> load byte, go PRESENT.
//    - If index==0, first copy reg_in into snapshot, in the same cycle.
//    - Byte = snapshot[(num_words-1-index)*word_width +: word_width].
//    - For index 0 the byte comes from the freshly captured reg_in value.
//  - PRESENT: drive data, ack=1, sel=1.
//    - last=1 when index==num_words-1.
//    - Go WAIT_LOW the next cycle.
//  - WAIT_LOW: keep data/ack/last/sel until sync r_clk=0.
//    - Then clear ack, zero data, sel=0.
//    - Index advances; it wraps num_words-1 -> 0. Go IDLE.
//  Latency
//  - r_clk rising at gpio_in -> ack=1 at gpio_out 3 clk edges later: 2 sync + 1 register.
//  - r_clk falling -> ack=0 3 edges later.
//  Address and re-arming
//  - A strobe with addr!=bus_addr is ignored: no state change; gpio_out stays 0.
//  - One byte per strobe; the strobe must drop to 0 before the next byte is served.
//  Resync
//  - Sync w_clk=1 with addr==bus_addr resets index to 0 while in IDLE; snapshot is untouched.
//  - The next read then takes a fresh snapshot.
//  - If w_clk and r_clk are both high, r_clk wins. Resync applies only after the read completes and w_clk is still high.
//  - In PRESENT or WAIT_LOW, w_clk is ignored.
//  Coherency
//  - reg_in is sampled only at index 0, so bytes 1..num_words-1 belong to the same snapshot.
//  - reg_in changes mid-sequence have no effect.
//  Reset mid-operation
//  - rst low in any state forces reset values immediately.
//  - The next read returns the MS byte of a new snapshot.
//  num_words=1: every read takes a new snapshot; last is always 1.
// TESTING
//  - Reset: rst low, any gpio_in -> gpio_out==0, sel==0. After release with no strobe, gpio_out stays 0.
//  - Full readout: reg_in=32'hDEADBEEF, 4 reads at addr 0 -> data DE,AD,BE,EF.
//    - ack rises 3 edges after each r_clk rise.
//    - last=1 only on EF.
//  - Coherency: after byte DE, set reg_in=32'h12345678 -> remaining bytes AD,BE,EF. Fifth read -> 12.
//  - Address filter: bus_addr=5, reads at addr 4 -> gpio_out==0, index unchanged. Next read at addr 5 -> MS byte.
//  - Resync: after 2 bytes, w_clk pulse at addr==bus_addr -> next read returns MS byte of a new snapshot.
//  - Mid-op reset: rst low during WAIT_LOW -> gpio_out==0 at once. After release, a read returns the MS byte of current reg_in.

Source files
------------

// File: rtl/status_reg_reader.sv
// rtl/status_reg_reader.sv - PL->PS status readback over the shared GPIO bus.
// Snapshots reg_in coherently and returns it MS byte first, one byte per r_clk strobe.
module status_reg_reader #(
  parameter int unsigned word_width = 8,
  parameter int unsigned num_words  = 4,
  parameter int unsigned addr_width = 16,
  parameter int unsigned bus_addr   = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [31:0]                       gpio_in,
  input  logic [num_words*word_width-1:0]   reg_in,
  output logic [31:0]                       gpio_out,
  output logic                              sel
);

  localparam int unsigned SNAP_W = num_words * word_width;
  localparam int unsigned IDX_W  = (num_words > 1) ? $clog2(num_words) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(num_words - 1);
  localparam logic [addr_width-1:0] MY_ADDR  = addr_width'(bus_addr);

  typedef enum logic [1:0] {IDLE, PRESENT, WAIT_LOW} state_e;

  state_e              state_q, state_d;
  logic [1:0]          r_sync_q, w_sync_q;
  logic [SNAP_W-1:0]   snap_q, snap_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [31:0]         out_q, out_d;
  logic                sel_q, sel_d;

  logic                addr_hit, r_hit, w_hit;
  logic [SNAP_W-1:0]   src;
  logic [31:0]         shift;
  logic [word_width-1:0] byte_val;
  logic                unused_gpio;

  assign addr_hit = (gpio_in[addr_width-1:0] == MY_ADDR);
  assign r_hit    = r_sync_q[1] & addr_hit;
  assign w_hit    = w_sync_q[1] & addr_hit;

  // Byte 0 is taken straight from reg_in in the same cycle it is snapshotted.
  assign src      = (idx_q == '0) ? reg_in : snap_q;
  assign shift    = 32'(LAST_IDX - idx_q) * word_width;
  assign byte_val = src[shift +: word_width];

  assign unused_gpio = ^{gpio_in[31:26], gpio_in[23:addr_width]};

  assign gpio_out = out_q;
  assign sel      = sel_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      r_sync_q <= 2'b00;
      w_sync_q <= 2'b00;
      snap_q   <= '0;
      idx_q    <= '0;
      out_q    <= '0;
      sel_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_sync_q <= {r_sync_q[0], gpio_in[25]};
      w_sync_q <= {w_sync_q[0], gpio_in[24]};
      snap_q   <= snap_d;
      idx_q    <= idx_d;
      out_q    <= out_d;
      sel_q    <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    out_d   = out_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (r_hit) begin
          if (idx_q == '0) snap_d = reg_in;
          out_d                   = '0;
          out_d[word_width-1:0]   = byte_val;
          out_d[30]               = 1'b1;
          out_d[31]               = (idx_q == LAST_IDX);
          sel_d                   = 1'b1;
          state_d                 = PRESENT;
        end else if (w_hit) begin
          idx_d = '0;
        end
      end
      PRESENT: begin
        state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        // Release on strobe fall regardless of address; the PS owns this transfer.
        if (!r_sync_q[1]) begin
          out_d   = '0;
          sel_d   = 1'b0;
          idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_status_reg_reader.sv
// tb/tb_status_reg_reader.sv - directed plus random bench for status_reg_reader.
// Three instances share gpio_in; their ORed gpio_out is compared against a byte-queue model.
module tb_status_reg_reader;

  logic        clk;
  logic        rst;
  logic [31:0] gpio_in;
  logic [31:0] reg_a, reg_b;
  logic [7:0]  reg_c;
  logic [31:0] out_a, out_b, out_c;
  logic        sel_a, sel_b, sel_c;
  logic [31:0] bus;
  logic [2:0]  sels;

  int vectors    = 0;
  int miscompares = 0;

  int          NW[3] = '{4, 4, 1};
  int          AD[3] = '{0, 5, 7};
  logic [31:0] m_snap[3];
  int          m_idx[3];
  logic [31:0] last_exp;

  status_reg_reader #(.word_width(8), .num_words(4), .addr_width(16), .bus_addr(0)) dut_a (
    .clk(clk), .rst(rst), .gpio_in(gpio_in), .reg_in(reg_a), .gpio_out(out_a), .sel(sel_a));
  status_reg_reader #(.word_width(8), .num_words(4), .addr_width(16), .bus_addr(5)) dut_b (
    .clk(clk), .rst(rst), .gpio_in(gpio_in), .reg_in(reg_b), .gpio_out(out_b), .sel(sel_b));
  status_reg_reader #(.word_width(8), .num_words(1), .addr_width(16), .bus_addr(7)) dut_c (
    .clk(clk), .rst(rst), .gpio_in(gpio_in), .reg_in(reg_c), .gpio_out(out_c), .sel(sel_c));

  assign bus  = out_a | out_b | out_c;
  assign sels = {sel_c, sel_b, sel_a};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cur_reg(input int i);
    case (i)
      0:       return reg_a;
      1:       return reg_b;
      default: return {24'h0, reg_c};
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_snap[i] = '0;
      m_idx[i]  = 0;
    end
  endtask

  // Raise r_clk at addr a, check the 3-edge ack latency and the presented byte.
  task automatic start_read(input logic [15:0] a, input bit with_w);
    logic [31:0] exp;
    logic [31:0] junk;
    logic [2:0]  sexp;
    logic [7:0]  b;
    exp  = '0;
    sexp = '0;
    for (int i = 0; i < 3; i++) begin
      if (32'(a) == AD[i]) begin
        if (m_idx[i] == 0) m_snap[i] = cur_reg(i);
        b = 8'(m_snap[i] >> (8 * (NW[i] - 1 - m_idx[i])));
        exp = {(m_idx[i] == NW[i] - 1), 1'b1, 22'h0, b};
        sexp[i] = 1'b1;
        m_idx[i] = (m_idx[i] + 1) % NW[i];
      end
    end
    junk = $urandom;
    gpio_in = junk;
    gpio_in[25] = 1'b1;
    gpio_in[24] = with_w;
    gpio_in[15:0] = a;
    tick();
    tick();
    chk("pre_ack", bus, 32'h0);
    tick();
    chk("present", bus, exp);
    chk("sel_present", 32'(sels), 32'(sexp));
    tick();
    tick();
    chk("hold", bus, exp);
    last_exp = exp;
  endtask

  task automatic end_read();
    logic [15:0] a;
    a = gpio_in[15:0];
    gpio_in[25] = 1'b0;
    tick();
    tick();
    chk("hold_fall", bus, last_exp);
    tick();
    chk("cleared", bus, 32'h0);
    chk("sel_cleared", 32'(sels), 32'h0);
    if (gpio_in[24]) begin
      for (int i = 0; i < 3; i++)
        if (32'(a) == AD[i]) m_idx[i] = 0;
      tick();
      gpio_in[24] = 1'b0;
    end
    tick();
    tick();
    tick();
  endtask

  task automatic do_read(input logic [15:0] a);
    start_read(a, 1'b0);
    end_read();
  endtask

  task automatic resync(input logic [15:0] a);
    gpio_in = $urandom;
    gpio_in[25] = 1'b0;
    gpio_in[24] = 1'b1;
    gpio_in[15:0] = a;
    for (int i = 0; i < 3; i++)
      if (32'(a) == AD[i]) m_idx[i] = 0;
    tick();
    tick();
    tick();
    chk("resync_quiet", bus, 32'h0);
    tick();
    gpio_in[24] = 1'b0;
    tick();
    tick();
    tick();
  endtask

  initial begin
    logic [15:0] ra;
    int          op;
    rst = 1'b0;
    gpio_in = 32'h0;
    gpio_in = $urandom;
    gpio_in[25] = 1'b1;
    reg_a = 32'hDEADBEEF;
    reg_b = $urandom;
    reg_c = 8'($urandom);
    model_reset();
    tick();
    tick();
    tick();
    chk("reset_out", bus, 32'h0);
    chk("reset_sel", 32'(sels), 32'h0);
    gpio_in = 32'h0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("idle_out", bus, 32'h0);

    // Full readout DE AD BE EF
    for (int i = 0; i < 4; i++) do_read(16'd0);
    chk("model_full", m_snap[0], 32'hDEADBEEF);

    // Coherency: reg_in change after the first byte is invisible until the next snapshot
    do_read(16'd0);
    reg_a = 32'h12345678;
    for (int i = 0; i < 3; i++) do_read(16'd0);
    do_read(16'd0);
    chk("coherent_new", last_exp, 32'h40000012);

    // Address filter
    do_read(16'd4);
    do_read(16'd4);
    do_read(16'd5);

    // Resync after two bytes
    resync(16'd0);
    do_read(16'd0);
    do_read(16'd0);
    reg_a = $urandom;
    resync(16'd0);
    do_read(16'd0);

    // r_clk and w_clk together: read wins, resync follows
    start_read(16'd0, 1'b1);
    end_read();
    reg_a = $urandom;
    do_read(16'd0);

    // Single-byte instance
    for (int i = 0; i < 3; i++) begin
      reg_c = 8'($urandom);
      do_read(16'd7);
    end

    // Reset during WAIT_LOW
    start_read(16'd5, 1'b0);
    rst = 1'b0;
    #1;
    chk("midop_out", bus, 32'h0);
    chk("midop_sel", 32'(sels), 32'h0);
    model_reset();
    gpio_in = 32'h0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    tick();
    reg_b = $urandom;
    do_read(16'd5);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0: ra = 16'd0;
        1: ra = 16'd5;
        2: ra = 16'd7;
        3: ra = 16'd4;
        default: ra = 16'($urandom);
      endcase
      if (op < 5) begin
        start_read(ra, 1'b0);
        if ($urandom_range(0, 1) == 1) begin
          reg_a = $urandom;
          reg_b = $urandom;
          reg_c = 8'($urandom);
        end
        end_read();
      end else if (op == 5) begin
        resync(ra);
      end else begin
        reg_a = $urandom;
        reg_b = $urandom;
        reg_c = 8'($urandom);
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
